// File: rtl/sprite_anim_ctrl.sv
// Draw / wait-for-tick / erase / advance sequencer that animates one rectangular
// sprite moving right across the screen, driving the VGA adapter's plot port.
module sprite_anim_ctrl #(
  parameter int SCREEN_W = 160,
  parameter int SPR_W    = 8,
  parameter int SPR_H    = 8,
  parameter int TICK_DIV = 833333,
  parameter int X_STEP   = 1
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       load,
  input  logic       go,
  input  logic [7:0] x_in,
  input  logic [6:0] y_in,
  input  logic [2:0] colour_in,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  localparam int PXW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int PYW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
  localparam int TW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [PXW-1:0] PX_LAST   = PXW'(SPR_W - 1);
  localparam logic [PYW-1:0] PY_LAST   = PYW'(SPR_H - 1);
  localparam logic [TW-1:0]  TICK_LOAD = TW'(TICK_DIV - 1);
  localparam logic [7:0]     X_MAX     = 8'(SCREEN_W - SPR_W);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DRAW      = 3'd1,
    WAIT_TICK = 3'd2,
    ERASE     = 3'd3,
    UPDATE    = 3'd4
  } state_e;

  state_e         state_q, state_d;
  logic [7:0]     x_pos_q, x_pos_d;
  logic [6:0]     y_pos_q, y_pos_d;
  logic [2:0]     col_q, col_d;
  logic [PXW-1:0] px_q, px_d;
  logic [PYW-1:0] py_q, py_d;
  logic [TW-1:0]  tick_q, tick_d;

  logic [8:0]     x_sum_s;
  logic           wrap_s;

  // Nine-bit sum so the wrap test cannot be fooled by an 8-bit overflow.
  assign x_sum_s = {1'b0, x_pos_q} + 9'(X_STEP);
  assign wrap_s  = (x_sum_s > {1'b0, X_MAX});

  always_comb begin
    state_d = state_q;
    x_pos_d = x_pos_q;
    y_pos_d = y_pos_q;
    col_d   = col_q;
    px_d    = px_q;
    py_d    = py_q;
    tick_d  = tick_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          x_pos_d = (x_in > X_MAX) ? X_MAX : x_in;
          y_pos_d = y_in;
          col_d   = colour_in;
        end else begin
          x_pos_d = x_pos_q;
        end
        if (go) begin
          state_d = DRAW;
          px_d    = '0;
          py_d    = '0;
        end else begin
          state_d = IDLE;
        end
      end
      DRAW, ERASE: begin
        if (px_q == PX_LAST) begin
          px_d = '0;
          if (py_q == PY_LAST) begin
            py_d = '0;
            if (state_q == ERASE) begin
              state_d = UPDATE;
            end else if (go) begin
              state_d = WAIT_TICK;
              tick_d  = TICK_LOAD;
            end else begin
              state_d = IDLE;
            end
          end else begin
            py_d = py_q + PYW'(1);
          end
        end else begin
          px_d = px_q + PXW'(1);
        end
      end
      WAIT_TICK: begin
        // Dropping go abandons the step with the sprite still on screen.
        if (!go) begin
          state_d = IDLE;
        end else if (tick_q == '0) begin
          state_d = ERASE;
          px_d    = '0;
          py_d    = '0;
        end else begin
          tick_d = tick_q - TW'(1);
        end
      end
      UPDATE: begin
        x_pos_d = wrap_s ? 8'd0 : x_sum_s[7:0];
        state_d = DRAW;
        px_d    = '0;
        py_d    = '0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      x_pos_q <= 8'd0;
      y_pos_q <= 7'd0;
      col_q   <= 3'b111;
      px_q    <= '0;
      py_q    <= '0;
      tick_q  <= '0;
    end else begin
      state_q <= state_d;
      x_pos_q <= x_pos_d;
      y_pos_q <= y_pos_d;
      col_q   <= col_d;
      px_q    <= px_d;
      py_q    <= py_d;
      tick_q  <= tick_d;
    end
  end

  // Plot port is a pure decode of state so it is valid in the same cycle.
  always_comb begin
    x      = 8'd0;
    y      = 7'd0;
    colour = 3'b000;
    plot   = 1'b0;
    done   = 1'b0;
    busy   = (state_q != IDLE);
    case (state_q)
      DRAW: begin
        plot   = 1'b1;
        x      = x_pos_q + 8'(px_q);
        y      = y_pos_q + 7'(py_q);
        colour = col_q;
      end
      ERASE: begin
        plot   = 1'b1;
        x      = x_pos_q + 8'(px_q);
        y      = y_pos_q + 7'(py_q);
        colour = 3'b000;
      end
      UPDATE: begin
        done = wrap_s;
      end
      default: begin
        plot = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_sprite_anim_ctrl.sv
// Scoreboard bench for sprite_anim_ctrl: stimulus predicts every plot/done event
// with its cycle number; a monitor pops and compares whenever the DUT outputs.
module tb_sprite_anim_ctrl;

  localparam int SW   = 4;
  localparam int SH   = 4;
  localparam int TD   = 4;
  localparam int XMAX = 160 - SW;
  localparam int PER  = 2 * SW * SH + TD + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic       go = 1'b0;
  logic [7:0] x_in = 8'd0;
  logic [6:0] y_in = 7'd0;
  logic [2:0] colour_in = 3'd0;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, busy, done;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         t;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic       p;
    logic       d;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  // Reference model state: what the sprite registers should hold.
  logic [7:0] mx = 8'd0;
  logic [6:0] my = 7'd0;
  logic [2:0] mc = 3'b111;

  sprite_anim_ctrl #(
    .SCREEN_W(160), .SPR_W(SW), .SPR_H(SH), .TICK_DIV(TD), .X_STEP(1)
  ) dut (
    .CLOCK_50(clk), .reset(rst), .load(load), .go(go),
    .x_in(x_in), .y_in(y_in), .colour_in(colour_in),
    .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every plot or done cycle must match the head of the scoreboard.
  always @(negedge clk) begin
    if (plot || done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output t=%0d got x=%0d y=%0d col=%0d plot=%0b done=%0b, expected no output",
                 cyc, x, y, colour, plot, done);
      end else begin
        e = exp_q.pop_front();
        if (e.t != cyc || e.x != x || e.y != y || e.c != colour || e.p != plot || e.d != done) begin
          errors++;
          $display("FAIL plot_event got t=%0d x=%0d y=%0d col=%0d plot=%0b done=%0b, expected t=%0d x=%0d y=%0d col=%0d plot=%0b done=%0b",
                   cyc, x, y, colour, plot, done, e.t, e.x, e.y, e.c, e.p, e.d);
        end
      end
    end
  end

  function automatic void push_item(input int t, input logic [7:0] xx, input logic [6:0] yy,
                                    input logic [2:0] cc, input logic pp, input logic dd);
    exp_t it;
    it.t = t; it.x = xx; it.y = yy; it.c = cc; it.p = pp; it.d = dd;
    exp_q.push_back(it);
  endfunction

  function automatic void push_sweep(input int t0, input logic [7:0] xp, input logic [6:0] yp,
                                     input logic [2:0] cc, input int npix);
    for (int i = 0; i < npix; i++)
      push_item(t0 + i, xp + 8'(i % SW), 7'((int'(yp) + i / SW) % 128), cc, 1'b1, 1'b0);
  endfunction

  function automatic logic [7:0] next_x(input logic [7:0] xp);
    int v;
    v = int'(xp) + 1;
    return (v > XMAX) ? 8'd0 : 8'(v);
  endfunction

  // One finished step: erase at +20, UPDATE at +36 (done only on wrap).
  function automatic logic [7:0] push_erase_update(input int tk, input logic [7:0] xp);
    int v;
    push_sweep(tk + SW * SH + TD, xp, my, 3'b000, SW * SH);
    v = int'(xp) + 1;
    if (v > XMAX) push_item(tk + PER - 1, 8'd0, 7'd0, 3'd0, 1'b0, 1'b1);
    return next_x(xp);
  endfunction

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, got, want);
    end
  endtask

  // Raise go (optionally with load), run nfull whole steps, drop go rel cycles
  // into the next step, then confirm the return to IDLE at the right cycle.
  task automatic run(input bit do_load, input logic [7:0] xin, input logic [6:0] yin,
                     input logic [2:0] cin, input int nfull, input int rel);
    int t0, tk, d, idle_t;
    logic [7:0] xp;
    if (do_load) begin
      load = 1'b1; x_in = xin; y_in = yin; colour_in = cin;
      mx = (int'(xin) > XMAX) ? 8'(XMAX) : xin;
      my = yin;
      mc = cin;
    end
    go = 1'b1;
    t0 = cyc + 1;
    xp = mx;
    for (int j = 0; j < nfull; j++) begin
      push_sweep(t0 + j * PER, xp, my, mc, SW * SH);
      xp = push_erase_update(t0 + j * PER, xp);
    end
    tk = t0 + nfull * PER;
    d  = tk + rel;
    push_sweep(tk, xp, my, mc, SW * SH);
    if (rel >= SW * SH + TD) begin
      xp = push_erase_update(tk, xp);
      push_sweep(tk + PER, xp, my, mc, SW * SH);
      idle_t = tk + PER + SW * SH;
    end else if (rel >= SW * SH) begin
      idle_t = d + 1;
    end else begin
      idle_t = tk + SW * SH;
    end
    mx = xp;
    @(negedge clk);
    load = 1'b0;
    if (d >= t0 + 6) begin
      wait_until(t0 + 5);
      load = 1'b1;
      x_in = 8'($urandom_range(0, 255));
      y_in = 7'($urandom_range(0, 127));
      colour_in = 3'($urandom_range(0, 7));
      @(negedge clk);
      load = 1'b0;
    end
    wait_until(d);
    go = 1'b0;
    wait_until(idle_t - 1);
    check("busy_before_idle", int'(busy), 1);
    @(negedge clk);
    check("busy_at_idle", int'(busy), 0);
    check("plot_at_idle", int'(plot), 0);
  endtask

  initial begin
    #1;
    check("reset_plot", int'(plot), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_xyc", int'({x, y, colour}), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", int'(busy), 0);

    // Load+go together, one full step, drop go mid-DRAW of the redraw.
    run(1'b1, 8'd10, 7'd20, 3'b100, 1, 5);
    // Clamp to 156, wrap to 0 with a done pulse.
    run(1'b1, 8'd200, 7'd30, 3'b010, 1, 10);
    // Drop in WAIT_TICK, then drop in ERASE and at UPDATE.
    run(1'b0, 8'd0, 7'd0, 3'd0, 0, 17);
    run(1'b0, 8'd0, 7'd0, 3'd0, 0, 25);
    run(1'b0, 8'd0, 7'd0, 3'd0, 1, 36);

    // Load alone in IDLE, go later without load.
    load = 1'b1; x_in = 8'd153; y_in = 7'd126; colour_in = 3'b001;
    mx = 8'd153; my = 7'd126; mc = 3'b001;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    check("load_idle_busy", int'(busy), 0);
    run(1'b0, 8'd0, 7'd0, 3'd0, 3, 30);

    // Reset in the middle of a DRAW sweep.
    go = 1'b1;
    push_sweep(cyc + 1, mx, my, mc, 8);
    wait_until(cyc + 8);
    #1 rst = 1'b1;
    #1;
    check("midreset_plot", int'(plot), 0);
    check("midreset_busy", int'(busy), 0);
    go = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    mx = 8'd0; my = 7'd0; mc = 3'b111;
    run(1'b0, 8'd0, 7'd0, 3'd0, 0, 3);

    for (int k = 0; k < 16; k++) begin
      run(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 7'($urandom_range(0, 127)),
          3'($urandom_range(0, 7)), int'($urandom_range(0, 2)), int'($urandom_range(0, PER - 1)));
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog t=%0d expected completion earlier", cyc);
    $fatal(1);
  end

endmodule
